axi_lite_8bit_master: RTL and testbench

//  AXI4-Lite initiator that pairs with the 8-bit AXI-Lite register slave. Turns single commands
//  (read or write) from a valid/ready command port into AW/W/B or AR/R channel transactions.

---
 rtl/axi_lite_8bit_master_pkg.sv | 21 ++
 rtl/axi_lite_8bit_master_watchdog.sv | 39 +++
 rtl/axi_lite_8bit_master.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_lite_8bit_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_8bit_master_pkg.sv
// Shared types and constants for the 8-bit AXI4-Lite master and its watchdog.
package axi_lite_8bit_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } master_state_e;

    // A zero timeout still needs a one-bit counter so the port widths stay legal.
    function automatic int wd_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/axi_lite_8bit_master_watchdog.sv
// Transaction watchdog: clear/enable up-counter that flags the last allowed cycle.
module axi_lite_8bit_master_watchdog
    import axi_lite_8bit_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int             CW   = wd_cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // TIMEOUT of zero disables expiry entirely; the counter then just free-runs.
    assign expire_o = (TIMEOUT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/axi_lite_8bit_master.sv
// AXI4-Lite initiator: one command in flight, turned into AW/W/B or AR/R traffic,
// with a watchdog that aborts a transfer the slave never completes.
module axi_lite_8bit_master
    import axi_lite_8bit_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic                      BREADY,
    input  logic                      BVALID,
    input  logic [1:0]                BRESP,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic                      RREADY,
    input  logic                      RVALID,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP
);

    master_state_e               state_q, state_d;
    logic                        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                        bready_q, bready_d, arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]       awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_WIDTH/8-1:0]     wstrb_q, wstrb_d;
    logic                        write_q, write_d, timeout_q, timeout_d;
    logic [1:0]                  resp_q, resp_d;
    logic                        wd_clear, wd_enable, wd_expire, abort;

    assign wd_clear  = (state_q == ST_IDLE) && cmd_valid;
    assign wd_enable = (state_q == ST_WADDR) || (state_q == ST_WRESP) ||
                       (state_q == ST_RADDR) || (state_q == ST_RDATA);

    axi_lite_8bit_master_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        abort     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WADDR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_WADDR: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end else if (wd_expire) begin
                    abort = 1'b1;
                end
            end
            ST_WRESP: begin
                if (BVALID && bready_q) begin
                    resp_d    = BRESP;
                    rdata_d   = '0;
                    timeout_d = 1'b0;
                    bready_d  = 1'b0;
                    state_d   = ST_RESP;
                end else if (wd_expire) begin
                    abort = 1'b1;
                end
            end
            ST_RADDR: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end else if (wd_expire) begin
                    abort = 1'b1;
                end
            end
            ST_RDATA: begin
                if (RVALID && rready_q) begin
                    rdata_d   = RDATA;
                    resp_d    = RRESP;
                    timeout_d = 1'b0;
                    rready_d  = 1'b0;
                    state_d   = ST_RESP;
                end else if (wd_expire) begin
                    abort = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort breaks the AXI no-retract rule on purpose; the slave needs a reset afterwards.
        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            resp_d    = RESP_SLVERR;
            timeout_d = 1'b1;
            rdata_d   = '0;
            state_d   = ST_RESP;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;
    assign AWADDR      = awaddr_q;
    assign AWVALID     = awvalid_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = wstrb_q;
    assign WVALID      = wvalid_q;
    assign BREADY      = bready_q;
    assign ARADDR      = araddr_q;
    assign ARVALID     = arvalid_q;
    assign RREADY      = rready_q;

endmodule

// File: tb/tb_axi_lite_8bit_master.sv
// Bench for axi_lite_8bit_master: behavioural two-register slave with tunable stalls,
// directed corner cases, then random commands checked against an array model.
module tb_axi_lite_8bit_master;

    logic       ACLK, ARESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [0:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [0:0] cmd_wstrb;
    logic       rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [0:0] AWADDR, ARADDR;
    logic       AWVALID, AWREADY, WVALID, WREADY, BREADY, BVALID;
    logic       ARVALID, ARREADY, RREADY, RVALID;
    logic [7:0] WDATA, RDATA;
    logic [0:0] WSTRB;
    logic [1:0] BRESP, RRESP;

    axi_lite_8bit_master #(.ADDR_WIDTH(1), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // ---------------- behavioural slave ----------------
    int         aw_delay, w_delay, ar_delay, r_delay;
    bit         aw_stall, r_stall;
    logic [1:0] slv_resp;
    int         aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic [7:0] slv_mem [2];
    logic       aw_got, w_got, r_pend;
    logic [0:0] s_awaddr, s_araddr;
    logic [7:0] s_wdata;
    logic [0:0] s_wstrb;

    assign AWREADY = AWVALID && !aw_stall && (aw_cnt >= aw_delay);
    assign WREADY  = WVALID && (w_cnt >= w_delay);
    assign ARREADY = ARVALID && (ar_cnt >= ar_delay);
    assign BRESP   = slv_resp;
    assign RRESP   = slv_resp;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            BVALID <= 1'b0; RVALID <= 1'b0; RDATA <= 8'h00;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= 8'h00; s_wstrb <= '0;
            slv_mem[0] <= 8'h00;
            slv_mem[1] <= 8'hA5;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            if (AWVALID && AWREADY) begin aw_got <= 1'b1; s_awaddr <= AWADDR; end
            if (WVALID && WREADY) begin w_got <= 1'b1; s_wdata <= WDATA; s_wstrb <= WSTRB; end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (aw_got && w_got && !BVALID) begin
                if (s_wstrb[0]) slv_mem[s_awaddr] <= s_wdata;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                BVALID <= 1'b1;
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                r_pend <= 1'b1; s_araddr <= ARADDR; r_cnt <= 0;
            end else if (r_pend && !r_stall) begin
                if (r_cnt >= r_delay) begin
                    RVALID <= 1'b1; RDATA <= slv_mem[s_araddr]; r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int         n_checks, n_errors;
    logic [7:0] model_mem [2];
    logic       axi_busy;

    assign axi_busy = AWVALID | WVALID | ARVALID | BREADY | RREADY;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_mem[0] = 8'h00;
        model_mem[1] = 8'hA5;
    endtask

    task automatic issue(input logic w, input logic [0:0] a, input logic [7:0] d, input logic [0:0] s);
        int n;
        @(negedge ACLK);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for the response, holds rsp_ready low for `hold` cycles checking that the
    // result stays put with the AXI side quiet, then accepts it.
    task automatic get_rsp(input string tag, input int hold, input logic ew,
                           input logic [7:0] ed, input logic [1:0] er, input logic et);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i <= hold; i++) begin
            chk(tag, {17'd0, rsp_valid, cmd_ready, axi_busy, rsp_write, rsp_rdata, rsp_resp, rsp_timeout},
                     {17'd0, 1'b1, 1'b0, 1'b0, ew, ed, er, et});
            if (i < hold) @(negedge ACLK);
        end
        rsp_ready = 1'b1;
        @(posedge ACLK);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic slave_defaults();
        aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;
        aw_stall = 1'b0; r_stall = 1'b0; slv_resp = 2'b00;
    endtask

    task automatic pulse_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        model_reset();
    endtask

    initial begin
        logic       w;
        logic [0:0] a, s;
        logic [7:0] d;
        int         hold, n;

        n_checks = 0; n_errors = 0;
        slave_defaults();
        model_reset();
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = 8'h00; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("reset_outs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout,
                           rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB}, 32'd0);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // basic write then read of the fixed register
        issue(1'b1, 1'b0, 8'h5A, 1'b1);
        model_mem[0] = 8'h5A;
        get_rsp("wr0", 0, 1'b1, 8'h00, 2'b00, 1'b0);
        issue(1'b0, 1'b1, 8'h00, 1'b0);
        get_rsp("rd1", 0, 1'b0, model_mem[1], 2'b00, 1'b0);

        // read back, and a strobe-less write must not change the target
        issue(1'b0, 1'b0, 8'h00, 1'b0);
        get_rsp("rd0", 0, 1'b0, 8'h5A, 2'b00, 1'b0);
        issue(1'b1, 1'b1, 8'h33, 1'b0);
        get_rsp("wr_nostrb", 0, 1'b1, 8'h00, 2'b00, 1'b0);
        issue(1'b0, 1'b1, 8'h00, 1'b0);
        get_rsp("rd1_kept", 0, 1'b0, 8'hA5, 2'b00, 1'b0);

        // consumer back-pressure on the response port
        slv_resp = 2'b10;
        issue(1'b0, 1'b0, 8'h00, 1'b0);
        get_rsp("hold10", 10, 1'b0, 8'h5A, 2'b10, 1'b0);
        slv_resp = 2'b00;

        // AW late, W immediate: W drops first, BREADY waits for both
        aw_delay = 3;
        issue(1'b1, 1'b1, 8'hC3, 1'b1);
        model_mem[1] = 8'hC3;
        @(negedge ACLK);
        chk("split_first", {29'd0, AWVALID, WVALID, BREADY}, 32'b110);
        @(negedge ACLK);
        chk("split_w_done", {29'd0, AWVALID, WVALID, BREADY}, 32'b100);
        n = 0;
        while (AWVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("split_both_done", {29'd0, AWVALID, WVALID, BREADY}, 32'b001);
        get_rsp("split_rsp", 0, 1'b1, 8'h00, 2'b00, 1'b0);
        slave_defaults();

        // watchdog: AW never accepted, abort 16 cycles after entering WADDR
        aw_stall = 1'b1;
        issue(1'b1, 1'b0, 8'h11, 1'b1);
        repeat (16) @(negedge ACLK);
        chk("wd_before", {28'd0, AWVALID, WVALID, BREADY, rsp_valid}, 32'b1000);
        @(negedge ACLK);
        chk("wd_fire", {28'd0, rsp_valid, rsp_timeout, rsp_resp}, 32'b1110);
        get_rsp("wd_rsp", 2, 1'b1, 8'h00, 2'b10, 1'b1);
        slave_defaults();
        pulse_reset();

        // reset during RDATA drops the transfer silently
        r_stall = 1'b1;
        issue(1'b0, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (!RREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("rdata_entered", {31'd0, RREADY}, 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("mid_reset", {29'd0, RREADY, rsp_valid, cmd_ready}, 32'b001);
        ARESET = 1'b0;
        slave_defaults();
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            chk("no_spurious", {29'd0, rsp_valid, axi_busy, cmd_ready}, 32'b001);
        end
        issue(1'b0, 1'b1, 8'h00, 1'b0);
        get_rsp("rd_after_reset", 0, 1'b0, 8'hA5, 2'b00, 1'b0);

        // random traffic against the array model
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            slv_resp = 2'($urandom_range(0, 3));
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            hold     = $urandom_range(0, 2);
            issue(w, a, d, s);
            if (w) begin
                if (s[0]) model_mem[a] = d;
                get_rsp("rnd_wr", hold, 1'b1, 8'h00, slv_resp, 1'b0);
            end else begin
                get_rsp("rnd_rd", hold, 1'b0, model_mem[a], slv_resp, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
